// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide.
// Optional MULDIV_FAST_MUL_EN: multiplies complete combinationally in one cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [W2-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  opa_q, opa_d, opb_q, opb_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              done_q, done_d;

  // Operand signs only count for the signed flavours of each op
  logic             sgn_a_in, sgn_b_in;
  logic [WIDTH-1:0] a_mag, b_mag;
  always_comb begin
    sgn_a_in = (op == 3'b001 || op == 3'b010 || op == 3'b100 || op == 3'b110) && opA[WIDTH-1];
    sgn_b_in = (op == 3'b001 || op == 3'b100 || op == 3'b110) && opB[WIDTH-1];
    a_mag    = sgn_a_in ? -opA : opA;
    b_mag    = sgn_b_in ? -opB : opB;
  end

  // One radix-2 step; acc holds {hi, lo} for multiply and {rem, quo} for divide
  logic [WIDTH:0]  add_sum, rem_shift, rem_trial;
  logic [W2-1:0]   mul_next, div_next;
  always_comb begin
    add_sum   = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : {WIDTH{1'b0}})};
    mul_next  = {add_sum, acc_q[WIDTH-1:1]};
    rem_shift = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
    rem_trial = rem_shift - {1'b0, b_q};
    div_next  = rem_trial[WIDTH] ? {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                 : {rem_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  end

  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] quo_s, rem_s;
  logic             divz, ovf;
  always_comb begin
    prod  = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo_s = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_s = sa_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
    divz  = (opb_q == '0);
    ovf   = (opa_q == {1'b1, {(WIDTH-1){1'b0}}}) && (opb_q == '1);
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    b_d     = b_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        op_d    = op;
        acc_d   = {{WIDTH{1'b0}}, a_mag};
        b_d     = b_mag;
        opa_d   = opA;
        opb_d   = opB;
        sa_d    = sgn_a_in;
        sb_d    = sgn_b_in;
        cnt_d   = '0;
        state_d = CALC;
`ifdef MULDIV_FAST_MUL_EN
        if (!op[2]) begin
          acc_d   = W2'(a_mag) * W2'(b_mag);
          state_d = FIX;
        end
`endif
      end
      CALC: begin
        acc_d = op_q[2] ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        case (op_q)
          3'b000:                 res_d = prod[WIDTH-1:0];
          3'b001, 3'b010, 3'b011: res_d = prod[W2-1:WIDTH];
          3'b100:  res_d = divz ? '1 : (ovf ? opa_q : quo_s);
          3'b101:  res_d = divz ? '1 : quo_s;
          3'b110:  res_d = divz ? opa_q : (ovf ? '0 : rem_s);
          default: res_d = divz ? opa_q : rem_s;
        endcase
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = res_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic vectors, special cases, and control timing.
module tb_muldiv_unit;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] opA, opB;
  logic        busy, done;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opA(opA), .opB(opB),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Drives one request and waits (bounded) for done; called at posedge+1.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int cyc, output int bcnt);
    op = o; opA = a; opB = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (busy) bcnt++;
    end
    res = result;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; op = '0; opA = '0; opB = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_no_start got=%b exp=0", busy); end
  endtask

  task automatic test_mul;
    logic [31:0] r;
    int cyc, bcnt;
    logic [2:0]  vo [5];
    logic [31:0] va [5], vb [5], ve [5];
    vo = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b011};
    va = '{32'h7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vb = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    ve = '{32'hFFFF_FFEB, 32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    for (int i = 0; i < 5; i++) begin
      run_op(vo[i], va[i], vb[i], r, cyc, bcnt);
      checks++;
      if (r !== ve[i]) begin failures++; $display("FAIL mul_result[%0d] got=%h exp=%h", i, r, ve[i]); end
      checks++;
      if (cyc !== MUL_LAT) begin failures++; $display("FAIL mul_latency[%0d] got=%0d exp=%0d", i, cyc, MUL_LAT); end
`ifndef MULDIV_FAST_MUL_EN
      if (i == 0) begin
        checks++;
        if (bcnt !== 33) begin failures++; $display("FAIL mul_busy_cycles got=%0d exp=33", bcnt); end
      end
`endif
    end
  endtask

  task automatic test_div;
    logic [31:0] r;
    int cyc, bcnt;
    logic [2:0]  vo [8];
    logic [31:0] va [8], vb [8], ve [8];
    vo = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b101, 3'b111, 3'b100, 3'b110};
    va = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    vb = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    ve = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
    for (int i = 0; i < 8; i++) begin
      run_op(vo[i], va[i], vb[i], r, cyc, bcnt);
      checks++;
      if (r !== ve[i]) begin failures++; $display("FAIL div_result[%0d] got=%h exp=%h", i, r, ve[i]); end
      checks++;
      if (cyc !== DIV_LAT) begin failures++; $display("FAIL div_latency[%0d] got=%0d exp=%0d", i, cyc, DIV_LAT); end
    end
  endtask

  task automatic test_ignore_start;
    int cyc;
    op = 3'b101; opA = 32'd100; opB = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin
      if (cyc == 5) begin op = 3'b000; opA = 32'd3; opB = 32'd3; start = 1'b1; end
      else start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    checks++; if (result !== 32'd14) begin failures++; $display("FAIL ignore_start_result got=%h exp=%h", result, 32'd14); end
    checks++; if (cyc !== DIV_LAT) begin failures++; $display("FAIL ignore_start_latency got=%0d exp=%0d", cyc, DIV_LAT); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_pulse_width got=%b exp=0", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_after_done got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid;
    int ndone;
    op = 3'b101; opA = 32'd100; opB = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    #1; rst = 1'b1; #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL midreset_done got=%b exp=0", done); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL midreset_result got=%h exp=0", result); end
    @(posedge clk); #1;
    rst = 1'b0;
    ndone = 0;
    repeat (40) begin @(posedge clk); #1; if (done) ndone++; end
    checks++; if (ndone !== 0) begin failures++; $display("FAIL midreset_no_done got=%0d exp=0", ndone); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    op = 3'b000; opA = 32'd7; opB = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    op = 3'b101; opA = 32'd100; opB = 32'd7;
    cyc = 0;
    while (!done && cyc < 100) begin @(posedge clk); #1; cyc++; end
    checks++; if (result !== 32'd21) begin failures++; $display("FAIL b2b_first_result got=%h exp=%h", result, 32'd21); end
    checks++; if (cyc !== MUL_LAT) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=%0d", cyc, MUL_LAT); end
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b exp=1", busy); end
    cyc = 0;
    while (!done && cyc < 100) begin @(posedge clk); #1; cyc++; end
    checks++; if (result !== 32'd14) begin failures++; $display("FAIL b2b_second_result got=%h exp=%h", result, 32'd14); end
    checks++; if (cyc !== DIV_LAT) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=%0d", cyc, DIV_LAT); end
  endtask

  initial begin
    test_reset;
    test_mul;
    test_div;
    test_ignore_start;
    test_reset_mid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
